axil_arb2: RTL and testbench
============================

AXIL_ARB2 -- requirements
Module: axil_arb2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the AXI-Lite data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the AXI-Lite address width.
REQ-003 The block SHALL have port M_AXI_aclk  input  1  sole clock; all logic on rising edge.
REQ-004 The block SHALL have port M_AXI_areset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  2  per-requester command valid; bit i = requester i.
REQ-006 The block SHALL have port req_ready  output  2  per-requester command accept pulse.
REQ-007 The block SHALL have port req_wr  input  2  per-requester command type: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr  input  2*ADDR_WIDTH  per-requester address; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 The block SHALL have port req_wdata  input  2*DATA_WIDTH  per-requester write data; same slicing rule.
REQ-010 The block SHALL have port rsp_valid  output  2  per-requester completion pulse.
REQ-011 The block SHALL have port rsp_rdata  output  DATA_WIDTH  read data of the completing transaction; 0 for writes.
REQ-012 The block SHALL have port rsp_resp  output  2  bresp/rresp of the completing transaction.
REQ-013 The block SHALL have ports M_AXI_awaddr (out, ADDR_WIDTH), M_AXI_awvalid (out, 1), M_AXI_awready (in, 1): write-address channel.
REQ-014 The block SHALL have ports M_AXI_wdata (out, DATA_WIDTH), M_AXI_wstrb (out, DATA_WIDTH/8, constant all-ones), M_AXI_wvalid (out, 1), M_AXI_wready (in, 1): write-data channel.
REQ-015 The block SHALL have ports M_AXI_bresp (in, 2), M_AXI_bvalid (in, 1), M_AXI_bready (out, 1): write-response channel.
REQ-016 The block SHALL have ports M_AXI_araddr (out, ADDR_WIDTH), M_AXI_arvalid (out, 1), M_AXI_arready (in, 1): read-address channel.
REQ-017 The block SHALL have ports M_AXI_rdata (in, DATA_WIDTH), M_AXI_rresp (in, 2), M_AXI_rvalid (in, 1), M_AXI_rready (out, 1): read-data channel.

Function
REQ-018 The block SHALL implement FSM states IDLE, WRITE, WRESP, READ, RDATA, with exactly one AXI-Lite transaction outstanding at any time.
REQ-019 In IDLE with any req_valid set, the block SHALL grant one requester round-robin: the requester other than last_grant wins when both are valid, otherwise the single valid one wins.
REQ-020 At grant, the block SHALL assert req_ready[g] for exactly one cycle, capture req_wr/addr/wdata of g on that edge, update last_grant to g, and move to WRITE (req_wr=1) or READ (req_wr=0).
REQ-021 In WRITE, the block SHALL assert awvalid and wvalid together from the cycle after grant, dropping each independently after its own valid&ready edge (simultaneous handshakes allowed); it SHALL move to WRESP once both have completed.
REQ-022 In WRESP, the block SHALL hold bready=1 and, on the bvalid edge, pulse rsp_valid[g] for one cycle with rsp_resp=bresp and rsp_rdata=0, then return to IDLE.
REQ-023 In READ, the block SHALL hold arvalid until the arready edge and then move to RDATA; in RDATA it SHALL hold rready=1 and, on the rvalid edge, pulse rsp_valid[g] with rsp_rdata=rdata and rsp_resp=rresp, then return to IDLE.
REQ-024 Minimum latency SHALL be: grant at cycle T, valid at T+1, bready/rready at T+2, rsp_valid at T+3 when the slave responds with zero wait states.
REQ-025 The block SHALL spend at least one IDLE cycle between transactions.
REQ-026 The block SHALL drive awaddr, wdata and araddr to 0 whenever the corresponding valid is low.
REQ-027 The block SHALL keep rsp_valid at most one-hot, and SHALL assert it only for the granted requester.
REQ-028 Error responses (SLVERR, DECERR) SHALL pass through unmodified, with no retry.
REQ-029 Requesters SHALL hold req_valid and the command until req_ready; the block places no requirement on a request withdrawn before grant.
REQ-030 The block SHALL not enforce a timeout; it waits indefinitely for the slave.

Reset
REQ-031 While M_AXI_areset=1 at a clock edge, the block SHALL enter IDLE, clear all outputs to 0 (wstrb excepted), and set last_grant=1 so that requester 0 wins first.
REQ-032 Reset mid-transaction SHALL abandon the transaction without any rsp_valid pulse.

Verification
REQ-033 Write, requester 0, addr 0x10, data 0xB00BFEED, slave always ready, bresp=0 -> AW/W valid for 1 cycle, rsp_valid=01 at grant+3, rsp_resp=0.
REQ-034 Read, requester 1, addr 0x1014, rvalid 4 cycles after arready, rdata 0x30000044 -> rsp_valid=10 with rsp_rdata=0x30000044, rready high for the full wait.
REQ-035 Both requesters continuously valid for 6 transactions -> grant order 0,1,0,1,0,1.
REQ-036 awready 3 cycles before wready -> awvalid drops after its handshake, wvalid held until its own, bready asserts only after both.
REQ-037 bresp=2'b10 -> rsp_resp=2'b10.
REQ-038 Reset asserted in RDATA -> all outputs 0 next edge and no rsp pulse; a subsequent simultaneous request from both requesters grants requester 0.

Source files
------------

// File: rtl/axil_arb2.sv
// axil_arb2 -- two-requester round-robin arbiter onto a single AXI-Lite master port.
//
// Accepts simple read/write commands from two requesters and issues them one at a
// time on the AXI-Lite master interface. Only one transaction is ever outstanding.
//
// Ports:
//   M_AXI_aclk, M_AXI_areset   clock and synchronous active-high reset
//   req_valid/ready/wr         per-requester command handshake and type (bit i = requester i)
//   req_addr, req_wdata        per-requester command payload, requester i in slice i
//   rsp_valid                  one-cycle completion pulse to the granted requester
//   rsp_rdata, rsp_resp        read data (0 for writes) and response code of that completion
//   M_AXI_aw*, w*, b*, ar*, r* AXI-Lite master channels (wstrb constant all-ones)
module axil_arb2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      M_AXI_aclk,
    input  logic                      M_AXI_areset,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_wr,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDR_WIDTH-1:0]     M_AXI_awaddr,
    output logic                      M_AXI_awvalid,
    input  logic                      M_AXI_awready,
    output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
    output logic                      M_AXI_wvalid,
    input  logic                      M_AXI_wready,
    input  logic [1:0]                M_AXI_bresp,
    input  logic                      M_AXI_bvalid,
    output logic                      M_AXI_bready,
    output logic [ADDR_WIDTH-1:0]     M_AXI_araddr,
    output logic                      M_AXI_arvalid,
    input  logic                      M_AXI_arready,
    input  logic [DATA_WIDTH-1:0]     M_AXI_rdata,
    input  logic [1:0]                M_AXI_rresp,
    input  logic                      M_AXI_rvalid,
    output logic                      M_AXI_rready
);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_t;

    state_t                  state_reg;
    logic                    last_grant_reg;
    logic                    grant_reg;
    logic                    issued_reg;     // valids already raised for the current command
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [1:0]              req_ready_reg;
    logic [1:0]              rsp_valid_reg;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
    logic [1:0]              rsp_resp_reg;
    logic                    awvalid_reg;
    logic                    wvalid_reg;
    logic                    bready_reg;
    logic                    arvalid_reg;
    logic                    rready_reg;
    logic                    grant_next;

    // Unpack the per-requester payload buses.
    logic [ADDR_WIDTH-1:0]   req_addr_arr  [2];
    logic [DATA_WIDTH-1:0]   req_wdata_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign req_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin pick: when both request, the one not served last wins.
    always_comb begin
        grant_next = last_grant_reg;
        if (req_valid == 2'b11)
            grant_next = ~last_grant_reg;
        else if (req_valid[0])
            grant_next = 1'b0;
        else if (req_valid[1])
            grant_next = 1'b1;
    end

    always_ff @(posedge M_AXI_aclk) begin
        if (M_AXI_areset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            issued_reg     <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            req_ready_reg  <= '0;
            rsp_valid_reg  <= '0;
            rsp_rdata_reg  <= '0;
            rsp_resp_reg   <= '0;
            awvalid_reg    <= 1'b0;
            wvalid_reg     <= 1'b0;
            bready_reg     <= 1'b0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
        end else begin
            // Pulsed outputs default low every cycle.
            req_ready_reg <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= '0;

            case (state_reg)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        req_ready_reg[grant_next] <= 1'b1;
                        grant_reg      <= grant_next;
                        last_grant_reg <= grant_next;
                        addr_reg       <= req_addr_arr[grant_next];
                        wdata_reg      <= req_wdata_arr[grant_next];
                        issued_reg     <= 1'b0;
                        state_reg      <= req_wr[grant_next] ? WRITE : READ;
                    end
                end

                WRITE: begin
                    if (!issued_reg) begin
                        // First cycle after grant: raise both channels together.
                        awvalid_reg <= 1'b1;
                        wvalid_reg  <= 1'b1;
                        issued_reg  <= 1'b1;
                    end else begin
                        // A channel whose valid is already low has completed its handshake.
                        if (awvalid_reg && M_AXI_awready)
                            awvalid_reg <= 1'b0;
                        if (wvalid_reg && M_AXI_wready)
                            wvalid_reg <= 1'b0;
                        if ((!awvalid_reg || M_AXI_awready) && (!wvalid_reg || M_AXI_wready)) begin
                            bready_reg <= 1'b1;
                            state_reg  <= WRESP;
                        end
                    end
                end

                WRESP: begin
                    if (M_AXI_bvalid) begin
                        bready_reg               <= 1'b0;
                        rsp_valid_reg[grant_reg] <= 1'b1;
                        rsp_resp_reg             <= M_AXI_bresp;
                        state_reg                <= IDLE;
                    end
                end

                READ: begin
                    if (!issued_reg) begin
                        arvalid_reg <= 1'b1;
                        issued_reg  <= 1'b1;
                    end else if (M_AXI_arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RDATA;
                    end
                end

                RDATA: begin
                    if (M_AXI_rvalid) begin
                        rready_reg               <= 1'b0;
                        rsp_valid_reg[grant_reg] <= 1'b1;
                        rsp_rdata_reg            <= M_AXI_rdata;
                        rsp_resp_reg             <= M_AXI_rresp;
                        state_reg                <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_resp      = rsp_resp_reg;
    assign M_AXI_awvalid = awvalid_reg;
    assign M_AXI_wvalid  = wvalid_reg;
    assign M_AXI_bready  = bready_reg;
    assign M_AXI_arvalid = arvalid_reg;
    assign M_AXI_rready  = rready_reg;
    assign M_AXI_wstrb   = '1;

    // Address/data buses read as zero whenever their channel is idle.
    assign M_AXI_awaddr  = awvalid_reg ? addr_reg  : '0;
    assign M_AXI_wdata   = wvalid_reg  ? wdata_reg : '0;
    assign M_AXI_araddr  = arvalid_reg ? addr_reg  : '0;

endmodule

// File: tb/tb_axil_arb2.sv
// Directed testbench for axil_arb2: drives inputs and samples outputs on the falling edge.
module tb_axil_arb2;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axil_arb2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .M_AXI_aclk(clk), .M_AXI_areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_awaddr(awaddr), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
        .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
        .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
        .M_AXI_araddr(araddr), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
        .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
    );

    task automatic test_reset();
        logic [10:0] ctl;
        areset = 1'b1;
        repeat (2) @(negedge clk);
        ctl = {req_ready, rsp_valid, rsp_resp, awvalid, wvalid, bready, arvalid, rready};
        n_checks++; if (ctl !== 11'd0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0", ctl); end
        n_checks++; if ({awaddr, wdata, araddr, rsp_rdata} !== 128'd0) begin n_fail++; $display("FAIL reset_bus: got %h want 0", {awaddr, wdata, araddr, rsp_rdata}); end
        n_checks++; if (wstrb !== 4'hF) begin n_fail++; $display("FAIL reset_wstrb: got %h want f", wstrb); end
        areset = 1'b0;
        @(negedge clk);
        $display("txn: reset done");
    endtask

    // Zero-wait write from requester 0: grant at T, AW/W at T+1, bready at T+2, rsp at T+3.
    task automatic test_write();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        req_valid = 2'b01; req_wr = 2'b01;
        req_addr[31:0] = 32'h10; req_wdata[31:0] = 32'hB00BFEED;
        @(negedge clk);
        for (int k = 0; k < 20 && req_ready == 2'b00; k++) @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_grant: got %b want 01", req_ready); end
        n_checks++; if (awvalid !== 1'b0) begin n_fail++; $display("FAIL wr_aw_early: got %b want 0", awvalid); end
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if ({awvalid, wvalid} !== 2'b11) begin n_fail++; $display("FAIL wr_valids_t1: got %b want 11", {awvalid, wvalid}); end
        n_checks++; if (awaddr !== 32'h10) begin n_fail++; $display("FAIL wr_awaddr: got %h want 00000010", awaddr); end
        n_checks++; if (wdata !== 32'hB00BFEED) begin n_fail++; $display("FAIL wr_wdata: got %h want b00bfeed", wdata); end
        @(negedge clk);
        n_checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin n_fail++; $display("FAIL wr_t2: aw/w/b got %b want 001", {awvalid, wvalid, bready}); end
        n_checks++; if (awaddr !== 32'h0) begin n_fail++; $display("FAIL wr_awaddr_idle: got %h want 0", awaddr); end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL wr_rsp_valid: got %b want 01", rsp_valid); end
        n_checks++; if ({rsp_resp, rsp_rdata, bready} !== 35'd0) begin n_fail++; $display("FAIL wr_rsp_fields: resp %b rdata %h bready %b want 0", rsp_resp, rsp_rdata, bready); end
        $display("txn: write req0 addr 10 rsp_valid %b resp %b", rsp_valid, rsp_resp);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wr_rsp_pulse: got %b want 00", rsp_valid); end
    endtask

    // Read from requester 1 with rvalid arriving 4 cycles after the AR handshake.
    task automatic test_read_wait();
        arready = 1'b1; rvalid = 1'b0;
        req_valid = 2'b10; req_wr = 2'b00; req_addr[63:32] = 32'h1014;
        @(negedge clk);
        for (int k = 0; k < 20 && req_ready == 2'b00; k++) @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rd_grant: got %b want 10", req_ready); end
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if ({arvalid, araddr} !== {1'b1, 32'h1014}) begin n_fail++; $display("FAIL rd_ar: valid %b addr %h want 1 00001014", arvalid, araddr); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if ({rready, arvalid, rsp_valid} !== 4'b1000) begin n_fail++; $display("FAIL rd_wait%0d: rready/arvalid/rsp got %b want 1000", k, {rready, arvalid, rsp_valid}); end
        end
        rvalid = 1'b1; rdata = 32'h30000044; rresp = 2'b00;
        @(negedge clk);
        rvalid = 1'b0; rdata = '0;
        n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL rd_rsp_valid: got %b want 10", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h30000044) begin n_fail++; $display("FAIL rd_rdata: got %h want 30000044", rsp_rdata); end
        n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL rd_rready_drop: got %b want 0", rready); end
        $display("txn: read req1 addr 1014 rdata %h", rsp_rdata);
        @(negedge clk);
    endtask

    // Both requesters always valid: grants alternate 0,1,0,1,0,1 and each completion returns to its owner.
    task automatic test_round_robin();
        logic [1:0] exp_g;
        logic [1:0] last_g;
        int grants;
        int rsps;
        grants = 0; rsps = 0; last_g = 2'b00;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        req_valid = 2'b11; req_wr = 2'b11;
        req_addr = {32'h200, 32'h100}; req_wdata = {32'h22222222, 32'h11111111};
        for (int k = 0; k < 100 && rsps < 6; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                exp_g = (grants % 2 == 0) ? 2'b01 : 2'b10;
                n_checks++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", grants, req_ready, exp_g); end
                last_g = req_ready;
                grants++;
                if (grants == 6) req_valid = 2'b00;
            end
            if (rsp_valid != 2'b00) begin
                n_checks++; if (rsp_valid !== last_g) begin n_fail++; $display("FAIL rr_rsp%0d: got %b want %b", rsps, rsp_valid, last_g); end
                $display("txn: rr write rsp_valid %b", rsp_valid);
                rsps++;
            end
        end
        n_checks++; if (rsps !== 6) begin n_fail++; $display("FAIL rr_count: got %0d completions want 6", rsps); end
        bvalid = 1'b0;
        @(negedge clk);
    endtask

    // awready 3 cycles ahead of wready, plus a SLVERR write response passed through.
    task automatic test_split_handshake();
        awready = 1'b1; wready = 1'b0; bvalid = 1'b0; bresp = 2'b10;
        req_valid = 2'b01; req_wr = 2'b01; req_addr[31:0] = 32'h40; req_wdata[31:0] = 32'hCAFE0001;
        @(negedge clk);
        for (int k = 0; k < 20 && req_ready == 2'b00; k++) @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL sp_grant: got %b want 01", req_ready); end
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if ({awvalid, wvalid} !== 2'b11) begin n_fail++; $display("FAIL sp_t1: got %b want 11", {awvalid, wvalid}); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if ({awvalid, wvalid, bready} !== 3'b010) begin n_fail++; $display("FAIL sp_wait%0d: aw/w/b got %b want 010", k, {awvalid, wvalid, bready}); end
        end
        n_checks++; if (wdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL sp_wdata_held: got %h want cafe0001", wdata); end
        wready = 1'b1;
        @(negedge clk);
        n_checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin n_fail++; $display("FAIL sp_after_w: aw/w/b got %b want 001", {awvalid, wvalid, bready}); end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        n_checks++; if ({rsp_valid, rsp_resp} !== 4'b0110) begin n_fail++; $display("FAIL sp_slverr: rsp_valid/resp got %b want 0110", {rsp_valid, rsp_resp}); end
        $display("txn: split write req0 resp %b", rsp_resp);
        @(negedge clk);
    endtask

    // Reset while waiting in RDATA with rvalid arriving: no completion, then requester 0 wins.
    task automatic test_reset_mid_read();
        logic [10:0] ctl;
        arready = 1'b1; rvalid = 1'b0;
        req_valid = 2'b01; req_wr = 2'b00; req_addr[31:0] = 32'h2000;
        @(negedge clk);
        for (int k = 0; k < 20 && req_ready == 2'b00; k++) @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        n_checks++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rst_in_rdata: rready got %b want 1", rready); end
        areset = 1'b1; rvalid = 1'b1; rdata = 32'hDEADBEEF;
        @(negedge clk);
        ctl = {req_ready, rsp_valid, rsp_resp, awvalid, wvalid, bready, arvalid, rready};
        n_checks++; if (ctl !== 11'd0) begin n_fail++; $display("FAIL rst_mid_ctl: got %b want 0", ctl); end
        n_checks++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 0", rsp_rdata); end
        areset = 1'b0; rvalid = 1'b0; rdata = '0;
        req_valid = 2'b11; req_wr = 2'b00;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_no_rsp: got %b want 00", rsp_valid); end
        for (int k = 0; k < 20 && req_ready == 2'b00; k++) @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant: got %b want 01", req_ready); end
        $display("txn: post-reset grant %b", req_ready);
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_round_robin();
        test_split_handshake();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
